// File: rtl/glitcbus_reg_arbiter.sv
// Arbitrates the internal register bus between the GLITCBUS slave (absolute priority) and one local master.
// Optional activity counters are built when GLITCBUS_ARB_STATS_EN is defined.
module glitcbus_reg_arbiter #(
    parameter int GB_HOLD = 2,
    parameter int ADR_W   = 16,
    parameter int DAT_W   = 32
) (
    input  logic             gclk_i,
    input  logic             grst_b_i,
    input  logic             gsel_b_i,
    input  logic [ADR_W-1:0] gb_adr_i,
    input  logic [DAT_W-1:0] gb_dat_i,
    input  logic             gb_wr_i,
    input  logic             gb_rd_i,
    output logic [DAT_W-1:0] gb_dat_o,
    input  logic             lcl_req_i,
    input  logic             lcl_wr_i,
    input  logic [ADR_W-1:0] lcl_adr_i,
    input  logic [DAT_W-1:0] lcl_dat_i,
    output logic             lcl_ack_o,
    output logic [DAT_W-1:0] lcl_dat_o,
    output logic [ADR_W-1:0] reg_adr_o,
    output logic [DAT_W-1:0] reg_dat_o,
    output logic             reg_wr_o,
    output logic             reg_rd_o,
    input  logic [DAT_W-1:0] reg_dat_i,
`ifdef GLITCBUS_ARB_STATS_EN
    output logic [15:0]      stat_gb_o,
    output logic [15:0]      stat_wait_o,
`endif
    output logic             err_o
);

    localparam int CNT_W = (GB_HOLD > 1) ? $clog2(GB_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LCL,
        ST_GB,
        ST_GB_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic               gsel_q;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               lcl_ack_q, lcl_ack_d;
    logic [DAT_W-1:0]   lcl_dat_q, lcl_dat_d;
    logic               err_q, err_d;

    assign gb_dat_o  = reg_dat_i;
    assign lcl_ack_o = lcl_ack_q;
    assign lcl_dat_o = lcl_dat_q;
    assign err_o     = err_q;

    always_ff @(posedge gclk_i or negedge grst_b_i) begin
        if (!grst_b_i) begin
            state_q    <= ST_IDLE;
            gsel_q     <= 1'b1;
            hold_cnt_q <= '0;
            lcl_ack_q  <= 1'b0;
            lcl_dat_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gsel_q     <= gsel_b_i;
            hold_cnt_q <= hold_cnt_d;
            lcl_ack_q  <= lcl_ack_d;
            lcl_dat_q  <= lcl_dat_d;
            err_q      <= err_d;
        end
    end

    // Bus parks on the GLITCBUS side; local accesses only get single-cycle slots while GSEL is idle.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        lcl_ack_d  = 1'b0;
        lcl_dat_d  = lcl_dat_q;
        err_d      = err_q;
        reg_adr_o  = gb_adr_i;
        reg_dat_o  = gb_dat_i;
        reg_wr_o   = 1'b0;
        reg_rd_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gb_wr_i || gb_rd_i) err_d = 1'b1;
                if (!gsel_q) begin
                    state_d = ST_GB;
                end else if (lcl_req_i && !lcl_ack_q) begin
                    state_d = ST_LCL;
                end
            end
            ST_LCL: begin
                reg_adr_o = lcl_adr_i;
                reg_dat_o = lcl_dat_i;
                reg_wr_o  = lcl_wr_i;
                reg_rd_o  = !lcl_wr_i;
                if (!lcl_wr_i) lcl_dat_d = reg_dat_i;
                lcl_ack_d = 1'b1;
                if (gb_wr_i || gb_rd_i) err_d = 1'b1;
                state_d = gsel_q ? ST_IDLE : ST_GB;
            end
            ST_GB: begin
                reg_wr_o = gb_wr_i;
                reg_rd_o = gb_rd_i;
                if (gsel_q) begin
                    state_d    = ST_GB_HOLD;
                    hold_cnt_d = CNT_W'(GB_HOLD - 1);
                end
            end
            ST_GB_HOLD: begin
                reg_wr_o = gb_wr_i;
                reg_rd_o = gb_rd_i;
                if (!gsel_q) begin
                    state_d = ST_GB;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef GLITCBUS_ARB_STATS_EN
    logic [15:0] stat_gb_q, stat_gb_d;
    logic [15:0] stat_wait_q, stat_wait_d;

    assign stat_gb_o   = stat_gb_q;
    assign stat_wait_o = stat_wait_q;

    // A grant is any entry into GB, including a back-to-back re-entry from the hold phase.
    always_comb begin
        stat_gb_d   = stat_gb_q;
        stat_wait_d = stat_wait_q;
        if ((state_q != ST_GB) && (state_d == ST_GB) && (stat_gb_q != 16'hFFFF)) begin
            stat_gb_d = stat_gb_q + 16'd1;
        end
        if (lcl_req_i && ((state_q == ST_GB) || (state_q == ST_GB_HOLD)) &&
            (stat_wait_q != 16'hFFFF)) begin
            stat_wait_d = stat_wait_q + 16'd1;
        end
    end

    always_ff @(posedge gclk_i or negedge grst_b_i) begin
        if (!grst_b_i) begin
            stat_gb_q   <= '0;
            stat_wait_q <= '0;
        end else begin
            stat_gb_q   <= stat_gb_d;
            stat_wait_q <= stat_wait_d;
        end
    end
`endif

endmodule

// File: tb/tb_glitcbus_reg_arbiter.sv
// Directed self-checking bench for glitcbus_reg_arbiter; all inputs change 1 time unit after a rising edge.
module tb_glitcbus_reg_arbiter;

    logic        gclk_i = 1'b0;
    logic        grst_b_i;
    logic        gsel_b_i;
    logic [15:0] gb_adr_i;
    logic [31:0] gb_dat_i;
    logic        gb_wr_i;
    logic        gb_rd_i;
    logic [31:0] gb_dat_o;
    logic        lcl_req_i;
    logic        lcl_wr_i;
    logic [15:0] lcl_adr_i;
    logic [31:0] lcl_dat_i;
    logic        lcl_ack_o;
    logic [31:0] lcl_dat_o;
    logic [15:0] reg_adr_o;
    logic [31:0] reg_dat_o;
    logic        reg_wr_o;
    logic        reg_rd_o;
    logic [31:0] reg_dat_i;
    logic        err_o;
`ifdef GLITCBUS_ARB_STATS_EN
    logic [15:0] stat_gb_o;
    logic [15:0] stat_wait_o;
`endif

    int numChecks = 0;
    int numFails  = 0;

    glitcbus_reg_arbiter #(.GB_HOLD(2), .ADR_W(16), .DAT_W(32)) dut (
        .gclk_i    (gclk_i),
        .grst_b_i  (grst_b_i),
        .gsel_b_i  (gsel_b_i),
        .gb_adr_i  (gb_adr_i),
        .gb_dat_i  (gb_dat_i),
        .gb_wr_i   (gb_wr_i),
        .gb_rd_i   (gb_rd_i),
        .gb_dat_o  (gb_dat_o),
        .lcl_req_i (lcl_req_i),
        .lcl_wr_i  (lcl_wr_i),
        .lcl_adr_i (lcl_adr_i),
        .lcl_dat_i (lcl_dat_i),
        .lcl_ack_o (lcl_ack_o),
        .lcl_dat_o (lcl_dat_o),
        .reg_adr_o (reg_adr_o),
        .reg_dat_o (reg_dat_o),
        .reg_wr_o  (reg_wr_o),
        .reg_rd_o  (reg_rd_o),
        .reg_dat_i (reg_dat_i),
`ifdef GLITCBUS_ARB_STATS_EN
        .stat_gb_o   (stat_gb_o),
        .stat_wait_o (stat_wait_o),
`endif
        .err_o     (err_o)
    );

    always #5 gclk_i = ~gclk_i;

    task automatic applyStimulus();
        @(posedge gclk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        assert (observed === expected)
        else begin
            numFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        grst_b_i  = 1'b0;
        gsel_b_i  = 1'b1;
        gb_adr_i  = 16'h00AA;
        gb_dat_i  = 32'h0;
        gb_wr_i   = 1'b0;
        gb_rd_i   = 1'b0;
        lcl_req_i = 1'b0;
        lcl_wr_i  = 1'b0;
        lcl_adr_i = 16'h0;
        lcl_dat_i = 32'h0;
        reg_dat_i = 32'h0;

        applyStimulus();
        applyStimulus();
        checkOutput("rst_ack", {31'b0, lcl_ack_o}, 32'd0);
        checkOutput("rst_ldat", lcl_dat_o, 32'd0);
        checkOutput("rst_err", {31'b0, err_o}, 32'd0);
        checkOutput("rst_wr", {31'b0, reg_wr_o}, 32'd0);
        checkOutput("rst_rd", {31'b0, reg_rd_o}, 32'd0);
        checkOutput("rst_park_adr", {16'b0, reg_adr_o}, 32'h00AA);
        grst_b_i = 1'b1;
        applyStimulus();

        $display("[TB] local write");
        lcl_req_i = 1'b1; lcl_wr_i = 1'b1; lcl_adr_i = 16'h0010; lcl_dat_i = 32'hDEADBEEF;
        #1;
        checkOutput("t1_idle_wr", {31'b0, reg_wr_o}, 32'd0);
        applyStimulus();
        checkOutput("t1_lcl_wr", {31'b0, reg_wr_o}, 32'd1);
        checkOutput("t1_lcl_rd", {31'b0, reg_rd_o}, 32'd0);
        checkOutput("t1_lcl_adr", {16'b0, reg_adr_o}, 32'h0010);
        checkOutput("t1_lcl_dat", reg_dat_o, 32'hDEADBEEF);
        checkOutput("t1_no_ack_yet", {31'b0, lcl_ack_o}, 32'd0);
        applyStimulus();
        checkOutput("t1_ack", {31'b0, lcl_ack_o}, 32'd1);
        checkOutput("t1_wr_drop", {31'b0, reg_wr_o}, 32'd0);
        checkOutput("t1_ldat_kept", lcl_dat_o, 32'd0);
        checkOutput("t1_err", {31'b0, err_o}, 32'd0);
        lcl_req_i = 1'b0;
        applyStimulus();
        checkOutput("t1_ack_pulse", {31'b0, lcl_ack_o}, 32'd0);

        $display("[TB] local read");
        lcl_req_i = 1'b1; lcl_wr_i = 1'b0; lcl_adr_i = 16'h0004; reg_dat_i = 32'h12345678;
        #1;
        checkOutput("t2_gbdat", gb_dat_o, 32'h12345678);
        applyStimulus();
        checkOutput("t2_rd", {31'b0, reg_rd_o}, 32'd1);
        checkOutput("t2_wr", {31'b0, reg_wr_o}, 32'd0);
        checkOutput("t2_adr", {16'b0, reg_adr_o}, 32'h0004);
        applyStimulus();
        checkOutput("t2_ack", {31'b0, lcl_ack_o}, 32'd1);
        checkOutput("t2_ldat", lcl_dat_o, 32'h12345678);
        lcl_req_i = 1'b0; reg_dat_i = 32'h0;
        applyStimulus();
        checkOutput("t2_ack_pulse", {31'b0, lcl_ack_o}, 32'd0);

        $display("[TB] GB priority and GB write in hold");
        gsel_b_i = 1'b0;
        applyStimulus();
        lcl_req_i = 1'b1; lcl_wr_i = 1'b1; lcl_adr_i = 16'h0030; lcl_dat_i = 32'h00000055;
        gb_adr_i = 16'h0020; gb_dat_i = 32'hCAFE0001;
        applyStimulus();
        checkOutput("t3_gb_wr", {31'b0, reg_wr_o}, 32'd0);
        checkOutput("t3_gb_adr", {16'b0, reg_adr_o}, 32'h0020);
        checkOutput("t3_no_ack", {31'b0, lcl_ack_o}, 32'd0);
        applyStimulus();
        gsel_b_i = 1'b1;
        applyStimulus();
        checkOutput("t3_still_gb", {31'b0, reg_wr_o}, 32'd0);
        applyStimulus();
        gb_wr_i = 1'b1;
        #1;
        checkOutput("t4_fwd_wr", {31'b0, reg_wr_o}, 32'd1);
        checkOutput("t4_fwd_adr", {16'b0, reg_adr_o}, 32'h0020);
        checkOutput("t4_fwd_dat", reg_dat_o, 32'hCAFE0001);
        applyStimulus();
        gb_wr_i = 1'b0;
        checkOutput("t4_err", {31'b0, err_o}, 32'd0);
        checkOutput("t3_hold_no_ack", {31'b0, lcl_ack_o}, 32'd0);
        applyStimulus();
        checkOutput("t3_idle_no_ack", {31'b0, lcl_ack_o}, 32'd0);
        checkOutput("t3_idle_wr", {31'b0, reg_wr_o}, 32'd0);
        applyStimulus();
        checkOutput("t3_lcl_wr", {31'b0, reg_wr_o}, 32'd1);
        checkOutput("t3_lcl_adr", {16'b0, reg_adr_o}, 32'h0030);
        applyStimulus();
        checkOutput("t3_ack", {31'b0, lcl_ack_o}, 32'd1);
        lcl_req_i = 1'b0;
        applyStimulus();

        $display("[TB] back-to-back GLITCBUS cycles");
        gsel_b_i = 1'b0;
        applyStimulus();
        gsel_b_i = 1'b1;
        applyStimulus();
        gsel_b_i = 1'b0; lcl_req_i = 1'b1;
        applyStimulus();
        checkOutput("t5_hold_wr", {31'b0, reg_wr_o}, 32'd0);
        checkOutput("t5_hold_rd", {31'b0, reg_rd_o}, 32'd0);
        applyStimulus();
        gb_rd_i = 1'b1; gsel_b_i = 1'b1; reg_dat_i = 32'hA5A5A5A5;
        #1;
        checkOutput("t5_regb_rd", {31'b0, reg_rd_o}, 32'd1);
        checkOutput("t5_regb_wr", {31'b0, reg_wr_o}, 32'd0);
        checkOutput("t5_gbdat", gb_dat_o, 32'hA5A5A5A5);
        applyStimulus();
        gb_rd_i = 1'b0;
        checkOutput("t5_err", {31'b0, err_o}, 32'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("t5_hold_no_ack", {31'b0, lcl_ack_o}, 32'd0);
        applyStimulus();
        checkOutput("t5_idle_wr", {31'b0, reg_wr_o}, 32'd0);
        checkOutput("t5_idle_no_ack", {31'b0, lcl_ack_o}, 32'd0);
        applyStimulus();
        checkOutput("t5_lcl_wr", {31'b0, reg_wr_o}, 32'd1);
        applyStimulus();
        checkOutput("t5_ack", {31'b0, lcl_ack_o}, 32'd1);
        lcl_req_i = 1'b0; reg_dat_i = 32'h0;
        applyStimulus();
`ifdef GLITCBUS_ARB_STATS_EN
        checkOutput("stat_gb", {16'b0, stat_gb_o}, 32'd3);
        checkOutput("stat_wait", {16'b0, stat_wait_o}, 32'd11);
`endif

        $display("[TB] stray GB strobe in IDLE");
        gb_rd_i = 1'b1;
        #1;
        checkOutput("t6_rd_blocked", {31'b0, reg_rd_o}, 32'd0);
        applyStimulus();
        gb_rd_i = 1'b0;
        checkOutput("t6_err_set", {31'b0, err_o}, 32'd1);
        applyStimulus();
        checkOutput("t6_err_sticky", {31'b0, err_o}, 32'd1);
        grst_b_i = 1'b0;
        #1;
        checkOutput("t6_err_clr", {31'b0, err_o}, 32'd0);
`ifdef GLITCBUS_ARB_STATS_EN
        checkOutput("stat_gb_rst", {16'b0, stat_gb_o}, 32'd0);
        checkOutput("stat_wait_rst", {16'b0, stat_wait_o}, 32'd0);
`endif
        applyStimulus();
        grst_b_i = 1'b1;

        $display("[TB] async reset during local slot");
        lcl_req_i = 1'b1; lcl_wr_i = 1'b1; lcl_adr_i = 16'h0040;
        applyStimulus();
        checkOutput("t7_lcl_wr", {31'b0, reg_wr_o}, 32'd1);
        grst_b_i = 1'b0;
        #1;
        checkOutput("t7_wr_drop", {31'b0, reg_wr_o}, 32'd0);
        applyStimulus();
        checkOutput("t7_no_ack", {31'b0, lcl_ack_o}, 32'd0);
        lcl_req_i = 1'b0; grst_b_i = 1'b1;
        applyStimulus();
        checkOutput("t7_no_ack_after", {31'b0, lcl_ack_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
